// File: rtl/subtractor_bla_pipe.sv
// rtl/subtractor_bla_pipe.sv - two-stage borrow-lookahead subtractor with valid/ready handshake
// Low half resolves in S1 and registers its carry; the high half resolves in S2 using that carry.
module subtractor_bla_pipe #(
  parameter int BW_DATA  = 32,
  parameter int BW_GROUP = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BW_DATA-1:0] i_A,
  input  logic [BW_DATA-1:0] i_B,
  input  logic               i_Bin,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_D,
  output logic               o_Bout,
  output logic               o_Z,
  output logic               o_V
);

  localparam int HALF = BW_DATA / 2;
  localparam int NG   = HALF / BW_GROUP;

  // Subtraction as a + ~b + !bin. Group G/P decide the carry between groups; bit carries inside a group only form sums.
  function automatic logic [HALF:0] add_half(input logic [HALF-1:0] a,
                                             input logic [HALF-1:0] bn,
                                             input logic            cin);
    logic [HALF-1:0] s;
    logic            c;
    logic            gc;
    logic            gp;
    logic            bc;
    logic            g;
    logic            p;
    s = '0;
    c = cin;
    for (int gi = 0; gi < NG; gi++) begin
      gc = 1'b0;
      gp = 1'b1;
      bc = c;
      for (int bi = 0; bi < BW_GROUP; bi++) begin
        g = a[gi*BW_GROUP+bi] & bn[gi*BW_GROUP+bi];
        p = a[gi*BW_GROUP+bi] | bn[gi*BW_GROUP+bi];
        s[gi*BW_GROUP+bi] = a[gi*BW_GROUP+bi] ^ bn[gi*BW_GROUP+bi] ^ bc;
        bc = g | (p & bc);
        gc = g | (p & gc);
        gp = gp & p;
      end
      c = gc | (gp & c);
    end
    return {c, s};
  endfunction

  logic            s1_v;
  logic [HALF-1:0] s1_d_lo;
  logic            s1_c;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;

  logic            s2_load;
  logic            s1_load;
  logic [HALF:0]   lo_sum;
  logic [HALF:0]   hi_sum;
  logic [BW_DATA-1:0] d_next;
  logic            v_next;

  assign s2_load = !o_valid || i_ready;
  assign s1_load = !s1_v || s2_load;
  assign o_ready = s1_load;

  assign lo_sum = add_half(i_A[HALF-1:0], ~i_B[HALF-1:0], ~i_Bin);
  assign hi_sum = add_half(s1_a_hi, ~s1_b_hi, s1_c);
  assign d_next = {hi_sum[HALF-1:0], s1_d_lo};
  assign v_next = (s1_a_hi[HALF-1] != s1_b_hi[HALF-1]) && (d_next[BW_DATA-1] != s1_a_hi[HALF-1]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v    <= 1'b0;
      s1_d_lo <= '0;
      s1_c    <= 1'b0;
      s1_a_hi <= '0;
      s1_b_hi <= '0;
    end else if (s1_load) begin
      s1_v <= i_valid;
      if (i_valid) begin
        s1_d_lo <= lo_sum[HALF-1:0];
        s1_c    <= lo_sum[HALF];
        s1_a_hi <= i_A[BW_DATA-1:HALF];
        s1_b_hi <= i_B[BW_DATA-1:HALF];
      end
    end
  end

  // Result registers only move on an S2 load, so they hold while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_D     <= '0;
      o_Bout  <= 1'b0;
      o_Z     <= 1'b0;
      o_V     <= 1'b0;
    end else if (s2_load) begin
      o_valid <= s1_v;
      if (s1_v) begin
        o_D    <= d_next;
        o_Bout <= !hi_sum[HALF];
        o_Z    <= (d_next == '0);
        o_V    <= v_next;
      end
    end
  end

endmodule
